// File: rtl/leddc_pkg.sv
// Shared types and defaults for the LEDDC grayscale PWM engine.
// Pure declarations: no latency, no backpressure.
package leddc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_NORMAL   = 1'b0;
    localparam logic MODE_SCRAMBLE = 1'b1;

    localparam int CH_DEF = 16;
    localparam int GW_DEF = 16;
    localparam int S_DEF  = 4;

endpackage

// File: rtl/leddc_pwm_gen_if.sv
// Control/data bundle between scan logic and the PWM engine; dim exists only with LEDDC_DIM_EN.
// Wires only: no latency, no backpressure (writes are always accepted).
interface leddc_pwm_gen_if #(
    parameter int CH = 16,
    parameter int GW = 16
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          Vsync;
    logic          mode;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [GW-1:0] wr_data;
`ifdef LEDDC_DIM_EN
    logic [2:0]    dim;
`endif
    logic [CH-1:0] OUT;
    logic          line_done;
    logic          busy;

`ifdef LEDDC_DIM_EN
    modport master (output Vsync, mode, wr_en, wr_ch, wr_data, dim,
                    input  OUT, line_done, busy);
    modport slave  (input  Vsync, mode, wr_en, wr_ch, wr_data, dim,
                    output OUT, line_done, busy);
`else
    modport master (output Vsync, mode, wr_en, wr_ch, wr_data,
                    input  OUT, line_done, busy);
    modport slave  (input  Vsync, mode, wr_en, wr_ch, wr_data,
                    output OUT, line_done, busy);
`endif

endinterface

// File: rtl/leddc_pwm_cmp.sv
// Per-channel PWM comparator: on = pos < (gray >> dim); dim input only with LEDDC_DIM_EN.
// Purely combinational, no backpressure.
module leddc_pwm_cmp #(
    parameter int GW = 16
) (
    input  logic [GW-1:0] gray,
    input  logic [GW-1:0] pos,
`ifdef LEDDC_DIM_EN
    input  logic [2:0]    dim,
`endif
    output logic          on
);

    logic [GW-1:0] eff;

`ifdef LEDDC_DIM_EN
    assign eff = gray >> dim;
`else
    assign eff = gray;
`endif

    assign on = (pos < eff);

endmodule

// File: rtl/leddc_pwm_gen.sv
// Double-buffered grayscale PWM engine, conventional or bit-rotated (scrambled) order; LEDDC_DIM_EN adds dim.
// OUT is registered, one cycle behind the count; shadow writes are always accepted, no backpressure.
module leddc_pwm_gen
    import leddc_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int GW = GW_DEF,
    parameter int S  = S_DEF
) (
    input  logic           GCK,
    input  logic           rst,
    leddc_pwm_gen_if.slave bus
);

    localparam int            CW      = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [GW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [GW-1:0] shadow_q [CH];
    logic [GW-1:0] shadow_d [CH];
    logic [GW-1:0] active_q [CH];
    logic [GW-1:0] active_d [CH];
    logic [GW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          vs_q, vs_d;
    logic [CH-1:0] out_q, out_d;
    logic          line_done_q, line_done_d;
`ifdef LEDDC_DIM_EN
    logic [2:0]    dim_q, dim_d;
`endif

    logic          rise;
    logic [GW-1:0] pos;
    logic [CH-1:0] hit;

    assign vs_d = bus.Vsync;
    assign rise = bus.Vsync & ~vs_q;

    // Rotating the count spreads each channel's on-time over 2^S segments.
    always_comb begin
        pos = cnt_q;
        if (mode_q == MODE_SCRAMBLE) begin
            pos = {cnt_q[GW-S-1:0], cnt_q[GW-1:GW-S]};
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        leddc_pwm_cmp #(.GW(GW)) u_cmp (
            .gray (active_q[c]),
            .pos  (pos),
`ifdef LEDDC_DIM_EN
            .dim  (dim_q),
`endif
            .on   (hit[c])
        );
    end

    // Out-of-range channel indices match no entry, so such writes drop silently.
    always_comb begin
        shadow_d = shadow_q;
        for (int c = 0; c < CH; c++) begin
            if (bus.wr_en && (bus.wr_ch == CW'(c))) begin
                shadow_d[c] = bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        mode_d      = mode_q;
        out_d       = '0;
        line_done_d = 1'b0;
`ifdef LEDDC_DIM_EN
        dim_d       = dim_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    // shadow_q is the pre-write value when a write shares this edge.
                    active_d = shadow_q;
                    mode_d   = bus.mode;
`ifdef LEDDC_DIM_EN
                    dim_d    = bus.dim;
`endif
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!bus.Vsync) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    out_d = hit;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        line_done_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.Vsync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            vs_q        <= 1'b0;
            out_q       <= '0;
            line_done_q <= 1'b0;
`ifdef LEDDC_DIM_EN
            dim_q       <= 3'd0;
`endif
            for (int c = 0; c < CH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            vs_q        <= vs_d;
            out_q       <= out_d;
            line_done_q <= line_done_d;
`ifdef LEDDC_DIM_EN
            dim_q       <= dim_d;
`endif
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.line_done = line_done_q;
    assign bus.busy      = (state_q == RUN);

endmodule
